// File: rtl/seg_scan_driver_if.sv
// Purpose: bundles the load-side inputs and the scan outputs of the segment driver.
// Latency: none, wires only.
// Backpressure: none; load is always accepted and the scan never stalls.
interface seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                blank_lz;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;

  // Producer side: drives the digits to display and watches the scan outputs.
  modport master (
    output value, dp, load, blank_lz,
    input  seg, an
  );

  // Driver side: consumes the display data and drives segments and anodes.
  modport slave (
    input  value, dp, load, blank_lz,
    output seg, an
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Purpose: multiplexed 7-segment scanner with shadowed data, optional hex glyphs and leading-zero blanking.
// Latency: load lands in the shadow at the load edge; seg/an show it from the next edge on.
// Backpressure: none; load is taken on any edge and the scan runs freely.
module seg_scan_driver #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter bit HEX_EN = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_driver_if.slave   bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  // scan position
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;

  // shadow copies; the display never looks at the live inputs
  logic [4*DIGITS-1:0] sh_value;
  logic [DIGITS-1:0]   sh_dp;
  logic                sh_blank_lz;

  // registered outputs
  logic [7:0]          seg_q;
  logic [DIGITS-1:0]   an_q;

  // decode path for the digit currently selected by idx
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lz;
  logic [DIGITS-1:0]   an_nxt;
  logic [7:0]          glyph;
  logic [7:0]          seg_nxt;

  // Prescaler and digit index: idx steps once per DIV-cycle slot and wraps after the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow capture on load; reset wins over a simultaneous load.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_value    <= '0;
      sh_dp       <= '0;
      sh_blank_lz <= 1'b0;
    end else if (bus.load) begin
      sh_value    <= bus.value;
      sh_dp       <= bus.dp;
      sh_blank_lz <= bus.blank_lz;
    end
  end

  // Leading-zero mask: walk from the most significant digit while every nibble seen so far is zero.
  // Digit 0 is never masked so an all-zero value still shows a single "0".
  always_comb begin
    lz_mask  = '0;
    zero_run = sh_blank_lz;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (sh_value[4*i +: 4] == 4'd0);
      if (i > 0) lz_mask[i] = zero_run;
    end
  end

  // Pick the nibble, dp bit, blank flag and anode bit for the current idx.
  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    an_nxt  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = sh_value[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_lz    = lz_mask[i];
        an_nxt[i] = 1'b1;
      end
    end
  end

  // Glyph table in {F,C,A,G,B,D,E,P} order; the P bit is always 0 here and filled from dp below.
  always_comb begin
    glyph = 8'h00;
    case (cur_nib)
      4'h0: glyph = 8'hEE;
      4'h1: glyph = 8'h48;
      4'h2: glyph = 8'h3E;
      4'h3: glyph = 8'h7C;
      4'h4: glyph = 8'hD8;
      4'h5: glyph = 8'hF4;
      4'h6: glyph = 8'hF6;
      4'h7: glyph = 8'h68;
      4'h8: glyph = 8'hFE;
      4'h9: glyph = 8'hFC;
      4'hA: glyph = HEX_EN ? 8'hFA : 8'h00;
      4'hB: glyph = HEX_EN ? 8'hD6 : 8'h00;
      4'hC: glyph = HEX_EN ? 8'hA6 : 8'h00;
      4'hD: glyph = HEX_EN ? 8'h5E : 8'h00;
      4'hE: glyph = HEX_EN ? 8'hB6 : 8'h00;
      4'hF: glyph = HEX_EN ? 8'hB2 : 8'h00;
      default: glyph = 8'h00;
    endcase
    seg_nxt = {(cur_lz ? 7'd0 : glyph[7:1]), cur_dp};
  end

  // Output registers: the first cycle of every slot is a dark gap to avoid ghosting between digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= 8'h00;
      an_q  <= '0;
    end else if (cnt == '0) begin
      seg_q <= 8'h00;
      an_q  <= '0;
    end else begin
      seg_q <= seg_nxt;
      an_q  <= an_nxt;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Purpose: self-checking bench for seg_scan_driver, one instance per HEX_EN setting, DIGITS=4, DIV=4.
// Latency: expectations are queued before each edge and compared #1 after it.
// Backpressure: none; stimulus is edge-by-edge.
module tb_seg_scan_driver;

  logic clk = 1'b0;
  logic rst;

  seg_scan_driver_if #(.DIGITS(4)) bus1 ();
  seg_scan_driver_if #(.DIGITS(4)) bus0 ();

  seg_scan_driver #(.DIGITS(4), .DIV(4), .HEX_EN(1'b1)) dut_hex (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  seg_scan_driver #(.DIGITS(4), .DIV(4), .HEX_EN(1'b0)) dut_bcd (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  always #5 clk = ~clk;

  // one table row: what to load and the glyph each digit must show, packed {d3,d2,d1,d0}
  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blz;
    logic [31:0] s_hex;
    logic [31:0] s_bcd;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [7:0] s_hex;
    logic [7:0] s_bcd;
  } exp_t;

  vec_t  tbl [7];
  exp_t  sbq [$];
  int    n;
  int    checks;
  int    errors;
  logic [31:0] cur_hex;
  logic [31:0] cur_bcd;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %02h want %02h", name, n, act, exp);
    end
  endtask

  // One clock edge: queue what the outputs must be after it, drive, then pop and compare.
  task automatic tick(input bit r, input bit ld, input int vi);
    exp_t e;
    int   c;
    int   d;
    c = n % 4;
    d = (n / 4) % 4;
    if (r || c == 0) begin
      e.an    = 4'b0000;
      e.s_hex = 8'h00;
      e.s_bcd = 8'h00;
    end else begin
      e.an    = 4'b0001 << d;
      e.s_hex = cur_hex[8*d +: 8];
      e.s_bcd = cur_bcd[8*d +: 8];
    end
    sbq.push_back(e);
    rst = r;
    if (ld) begin
      bus1.value    = tbl[vi].value;
      bus1.dp       = tbl[vi].dp;
      bus1.blank_lz = tbl[vi].blz;
      bus1.load     = 1'b1;
      bus0.value    = tbl[vi].value;
      bus0.dp       = tbl[vi].dp;
      bus0.blank_lz = tbl[vi].blz;
      bus0.load     = 1'b1;
    end
    @(posedge clk);
    #1;
    bus1.load = 1'b0;
    bus0.load = 1'b0;
    if (r) begin
      n       = 0;
      cur_hex = 32'hEEEEEEEE;
      cur_bcd = 32'hEEEEEEEE;
    end else begin
      n++;
      if (ld) begin
        cur_hex = tbl[vi].s_hex;
        cur_bcd = tbl[vi].s_bcd;
      end
    end
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard empty at edge %0d", n);
    end else begin
      e = sbq.pop_front();
      check("an_hex",  {4'b0000, bus1.an}, {4'b0000, e.an});
      check("seg_hex", bus1.seg, e.s_hex);
      check("an_bcd",  {4'b0000, bus0.an}, {4'b0000, e.an});
      check("seg_bcd", bus0.seg, e.s_bcd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    n      = 0;
    cur_hex = 32'hEEEEEEEE;
    cur_bcd = 32'hEEEEEEEE;

    tbl[0] = '{16'h1234, 4'b0000, 1'b0, 32'h483E7CD8, 32'h483E7CD8};
    tbl[1] = '{16'h0070, 4'b0000, 1'b1, 32'h000068EE, 32'h000068EE};
    tbl[2] = '{16'h0000, 4'b0000, 1'b1, 32'h000000EE, 32'h000000EE};
    tbl[3] = '{16'hABCD, 4'b0010, 1'b0, 32'hFAD6A75E, 32'h00000100};
    tbl[4] = '{16'h0500, 4'b1000, 1'b1, 32'h01F4EEEE, 32'h01F4EEEE};
    tbl[5] = '{16'h5678, 4'b0101, 1'b0, 32'hF4F768FF, 32'hF4F768FF};
    tbl[6] = '{16'h9999, 4'b0000, 1'b0, 32'hFCFCFCFC, 32'hFCFCFCFC};

    rst = 1'b1;
    bus1.value = '0; bus1.dp = '0; bus1.load = 1'b0; bus1.blank_lz = 1'b0;
    bus0.value = '0; bus0.dp = '0; bus0.load = 1'b0; bus0.blank_lz = 1'b0;

    // reset held three edges, then release: one dark cycle, then digit 0 shows "0"
    repeat (3) tick(1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, 0);

    // table vectors: load on the last edge of a frame, then watch one full frame
    for (int vi = 0; vi < 6; vi++) begin
      while (n % 16 != 15) tick(1'b0, 1'b0, 0);
      tick(1'b0, 1'b1, vi);
      repeat (16) tick(1'b0, 1'b0, 0);
    end

    // load at cnt=3, idx=0: digit 1 must show the new 9 in its first lit cycle
    while (n % 16 != 3) tick(1'b0, 1'b0, 0);
    tick(1'b0, 1'b1, 6);
    repeat (5) tick(1'b0, 1'b0, 0);

    // reset mid-scan while digit 2 is lit: dark cycle after release, then digit 0 from zeroed shadow
    while (n % 16 != 9) tick(1'b0, 1'b0, 0);
    tick(1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, 0);

    // reset together with load: the load is dropped, shadow stays zero for a whole frame
    tick(1'b1, 1'b1, 5);
    repeat (18) tick(1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter DIV, default 50000: clock cycles per digit slot; legal range >= 2.
REQ-003 Parameter HEX_EN, default 0: 1 = decode nibbles 10..15 as A,b,C,d,E,F; 0 = BCD only.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port value, input, 4*DIGITS: one nibble per digit; digit i = value[4i+3:4i], digit 0 least significant.
REQ-007 Port dp, input, DIGITS: decimal point request per digit; bit i = digit i.
REQ-008 Port load, input, 1: when high at an edge, value, dp and blank_lz are captured into shadow registers.
REQ-009 Port blank_lz, input, 1: leading-zero blanking enable; captured with load.
REQ-010 Port seg, output, 8: registered segment drive, active high, bit order {F,C,A,G,B,D,E,P} (bit7 = F ... bit0 = P).
REQ-011 Port an, output, DIGITS: registered digit enable, one-hot, active high.

Function
REQ-012 Prescaler cnt SHALL count 0..DIV-1 and wrap to 0; digit index idx SHALL advance by 1 when cnt == DIV-1, wrapping DIGITS-1 -> 0.
REQ-013 Shadow registers SHALL update only on an edge with load=1; the display SHALL use only the shadow copies.
REQ-014 At each edge, an SHALL be set to 0 if cnt == 0 (blanking interval); otherwise an SHALL be set to one-hot(idx).
REQ-015 At each edge, seg SHALL be set to 0x00 if cnt == 0; otherwise seg SHALL be set to decode(shadow digit idx) with bit0 = shadow dp[idx].
REQ-016 Decode table (hex): 0=EE, 1=48, 2=3E, 3=7C, 4=D8, 5=F4, 6=F6, 7=68, 8=FE, 9=FC.
REQ-017 HEX_EN=1: A=FA, b=D6, C=A6, d=5E, E=B6, F=B2. HEX_EN=0: nibbles 10..15 SHALL drive segment bits 7:1 = 0; bit0 still follows dp.
REQ-018 Leading-zero blanking: with shadow blank_lz=1, a digit i > 0 whose nibble and all more-significant nibbles are 0 SHALL drive segment bits 7:1 = 0 and bit0 = dp; an is unchanged.
REQ-019 Digit 0 SHALL never be blanked by REQ-018; value 0 shows "0" on digit 0.
REQ-020 Latency: load at edge k updates the shadow at edge k; seg and an reflect the new shadow from edge k+1 onward.
REQ-021 Load at the same edge as an idx wrap: the new idx SHALL display the new shadow data with no stale slot.
REQ-022 Each digit slot SHALL be DIV cycles long: 1 blank cycle, then DIV-1 cycles with the digit on. The full frame SHALL be DIGITS*DIV cycles.

Reset
REQ-023 While rst=1 at an edge: cnt=0, idx=0, shadow value=0, shadow dp=0, shadow blank_lz=0, seg=0x00, an=0. rst SHALL override load.
REQ-024 On the first edge after rst deasserts, cnt=0 is decoded, so seg=0x00 and an=0. Digit 0 is enabled on the following edge.
REQ-025 Reset asserted mid-scan SHALL abort the current slot; no partial state SHALL survive.

Verification (DIGITS=4, DIV=4)
REQ-026 Reset test: hold rst for 3 cycles, then release. Required: seg=00 and an=0000 during reset and on the first cycle after release. On the next cycle, an=0001 and seg=EE.
REQ-027 Scan test: load value=0x1234 with blank_lz=0. Required an sequence 0001, 0010, 0100, 1000, with seg D8, 7C, 3E, 48 respectively. Each digit is held 3 cycles, separated by a 1-cycle an=0000, seg=00 gap.
REQ-028 Blanking test, part 1: load value=0x0070 with blank_lz=1. Required: digits 3 and 2 show seg=00 with an still one-hot; digit 1 shows 68; digit 0 shows EE.
REQ-029 Blanking test, part 2: load value=0x0000 with blank_lz=1. Required: only digit 0 shows EE.
REQ-030 Hex/dp test: value=0xABCD, dp=0010. HEX_EN=1: digits 0..3 show 5E, A7, D6, FA. HEX_EN=0: digits 0..3 show 00, 01, 00, 00.
REQ-031 Boundary test: assert load at cnt=3, idx=0 with new value=0x9999. Required: digit 1 shows FC in its first lit cycle. Then assert rst while idx=2. Required: cnt=0 and idx=0, with an=0000 and seg=00 on the cycle after release.
